sub_serial_reg: RTL and testbench
=================================

// Module: sub_serial_reg
// PURPOSE
//  Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
//  through a single full-subtractor cell. Inverse companion to the registered
//  ripple adder. Trades latency for area.
//  Sits behind a start/done handshake; diff/bout are registered outputs.
// PARAMETERS
//  WIDTH  8  operand / result width in bits (>=2)
// PORTS
//  clk    in   1      rising-edge clock (single clock domain)
//  rst_n  in   1      asynchronous reset, active-low
//  start  in   1      request; sampled only when idle or in DONE
//  a      in   WIDTH  minuend, captured on accepted start
//  b      in   WIDTH  subtrahend, captured on accepted start
//  bin    in   1      borrow-in, captured on accepted start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse: result valid
//  diff   out  WIDTH  difference, held until next completion
//  bout   out  1      borrow-out, held with diff
//  ovf    out  1      signed overflow (only with SUB_OVF_EN)
// BEHAVIOUR
//  - rst_n low (any time, async): state=IDLE; busy,done,diff,bout,ovf=0;
//    shift regs and bit counter cleared. An operation in flight is discarded
//    and done never pulses for it.
//  - FSM IDLE -> RUN -> DONE:
//    IDLE: start=1 at edge -> latch a,b into shift regs, borrow reg=bin,
//      cnt=0, go RUN. start=0 -> stay.
//    RUN: per cycle, bit i = LSB of the shift regs:
//      d = a_i ^ b_i ^ br; br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
//      d is shifted into the result reg from the MSB side; operand regs shift
//      right; cnt++. At cnt==WIDTH-1 go DONE. start ignored in RUN.
//    DONE: lasts one cycle. done=1, busy=0. diff=result reg, bout=final br
//      (loaded on the RUN->DONE edge). start=1 here is accepted as in IDLE
//      (back-to-back: go RUN). Otherwise go IDLE.
//  - Latency: start accepted at edge 0 -> busy high for cycles 1..WIDTH,
//    done high in cycle WIDTH+1. Throughput: 1 op per WIDTH+1 cycles.
//  - Arithmetic: {bout,diff} = ({1'b0,a} - {1'b0,b} - bin) mod 2^(WIDTH+1).
//    bout=1 iff a < b+bin (unsigned). Wrap-around is modular, not saturated.
//  - diff/bout change only on the RUN->DONE edge or reset. Input changes
//    after capture have no effect.
//  - busy and done are never high together.
// CONFIGURATION
//  SUB_OVF_EN defined: port ovf present; loaded with diff on RUN->DONE as
//    ovf = (a[W-1]^b[W-1]) & (a[W-1]^diff[W-1]), using the captured
//    operand MSBs (two's-complement overflow); held with diff; reset 0.
//  SUB_OVF_EN undefined: no ovf port; no MSB capture logic.
// TESTING
//  1 a=8'h5A,b=8'h23,bin=0, start at edge 0 -> busy cycles 1..8,
//    done=1 cycle 9 only, diff=8'h37, bout=0.
//  2 a=8'h00,b=8'h01,bin=0 -> diff=8'hFF, bout=1 (wrap).
//  3 a=8'hFF,b=8'hFF,bin=1 -> diff=8'hFF, bout=1.
//  4 start a=8'h10,b=8'h01, then start a=8'hAA,b=8'h55 in cycle 3 ->
//    second ignored; diff=8'h0F; start held through DONE -> new op
//    (8'hAA-8'h55 -> diff=8'h55, bout=0), no idle cycle.
//  5 rst_n low in RUN cycle 4 -> busy,done,diff,bout=0 immediately; no done
//    pulse; after release a new start completes normally.
//  6 SUB_OVF_EN: a=8'h80,b=8'h01 -> diff=8'h7F, ovf=1, bout=0;
//    a=8'h10,b=8'h20 -> diff=8'hF0, ovf=0, bout=1.

Source files
------------

// File: rtl/sub_serial_reg.sv
// Bit-serial subtractor, LSB first, start/done handshake.
// Optional SUB_OVF_EN adds a registered signed-overflow output ovf.
module sub_serial_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last;
`ifdef SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Single full-subtractor cell on the current LSBs
    always_comb begin
        d       = sa[0] ^ sb[0] ^ br;
        br_nxt  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        res_nxt = {d, res[WIDTH-1:1]};
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_nxt;
                    br  <= br_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= res_nxt;
                        bout  <= br_nxt;
`ifdef SUB_OVF_EN
                        ovf   <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial_reg.sv
// Directed bench for sub_serial_reg: vector table plus handshake,
// back-to-back and reset-in-flight sequences.
module tb_sub_serial_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    sub_serial_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SUB_OVF_EN
        .bout  (bout),
        .ovf   (ovf)
`else
        .bout  (bout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op from a negedge; check busy/done timing and result.
    task automatic do_op(input vec_t v, input string name);
        logic tim_ok;
        tim_ok = 1'b1;
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        bin   = v.bin;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = ~v.a;
        b     = ~v.b;
        bin   = ~v.bin;
        for (int c = 1; c <= W; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) tim_ok = 1'b0;
            if (c < W) @(negedge clk);
        end
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b1) tim_ok = 1'b0;
        chk({name, " timing"}, {31'd0, tim_ok}, 32'd1);
        chk({name, " diff"}, {24'd0, diff}, {24'd0, v.d});
        chk({name, " bout"}, {31'd0, bout}, {31'd0, v.bo});
`ifdef SUB_OVF_EN
        chk({name, " ovf"}, {31'd0, ovf}, {31'd0, v.ov});
`endif
        @(negedge clk);
        chk({name, " done drop"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        logic seen;
        vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h01, 8'h80, 1'b0, 8'h81, 1'b1, 1'b1};
        vecs[8] = '{8'hC3, 8'h3C, 1'b1, 8'h86, 1'b0, 1'b0};
        vecs[9] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #12;
        chk("reset outs", {22'd0, busy, done, diff, bout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_op(vecs[i], $sformatf("vec%0d", i));

        // Mid-run start ignored, then start held through DONE
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        repeat (6) @(negedge clk);
        chk("b2b done1", {30'd0, busy, done}, 32'd1);
        chk("b2b diff1", {24'd0, diff, bout}, {23'd0, 8'h0F, 1'b0});
        @(negedge clk);
        start = 1'b0;
        chk("b2b no idle", {30'd0, busy, done}, 32'd2);
        repeat (W) @(negedge clk);
        chk("b2b done2", {30'd0, busy, done}, 32'd1);
        chk("b2b diff2", {24'd0, diff, bout}, {23'd0, 8'h55, 1'b0});
        @(negedge clk);

        // Reset while in RUN cycle 4
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h11;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-rst busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst", {22'd0, busy, done, diff, bout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 2 * W; c++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("no stale done", {31'd0, seen}, 32'd0);
        do_op(vecs[0], "post-rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
